moving_avg_ctrl: RTL and testbench

Sequencing controller for the moving-average datapath (delay-line BRAM, comb, integrator). It owns the datapath reset, which holds the integrator at zero, and clears the delay line by writing WINDOW_LEN zeros. It gates and re-times input samples into the datapath and suppresses outputs until the window is fully populated. It also decimates the averaged stream before it reaches the software-readable snapshot / power-accumulation stages.

---
 rtl/moving_avg_ctrl_if.sv | 34 +++
 rtl/moving_avg_ctrl.sv | 145 ++++++++++++++
 tb/tb_moving_avg_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/moving_avg_ctrl_if.sv
// Signal bundle between the moving-average controller and its environment
// (upstream source, datapath, and downstream snapshot/power stages).
interface moving_avg_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEC_WIDTH  = 16
);
    // Every *valid strobe is a single-cycle, valid-only qualifier: the data
    // beside it is meaningful exactly in the cycle it is high, and there is
    // no ready/backpressure path anywhere in this bundle.
    logic                         enable;
    logic                         sync_in;
    logic        [DEC_WIDTH-1:0]  dec_len;
    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic                         ma_rst;
    logic signed [DATA_WIDTH-1:0] ma_din;
    logic                         ma_din_valid;
    logic signed [DATA_WIDTH-1:0] ma_dout;
    logic                         ma_dout_valid;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         dout_valid;
    logic        [1:0]            state;
    logic                         filled;

    modport master (
        output enable, sync_in, dec_len, din, din_valid, ma_dout, ma_dout_valid,
        input  ma_rst, ma_din, ma_din_valid, dout, dout_valid, state, filled
    );

    modport slave (
        input  enable, sync_in, dec_len, din, din_valid, ma_dout, ma_dout_valid,
        output ma_rst, ma_din, ma_din_valid, dout, dout_valid, state, filled
    );
endinterface

// File: rtl/moving_avg_ctrl.sv
// Sequencer for the moving-average datapath: flushes the delay line, gates
// samples in, hides the fill transient and decimates the averaged stream.
module moving_avg_ctrl #(
    parameter int WINDOW_LEN = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEC_WIDTH  = 16,
    parameter int PIPE_LAT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    moving_avg_ctrl_if.slave   bus
);
    localparam int FLUSH_LEN = WINDOW_LEN + PIPE_LAT;
    localparam int FLUSH_W   = $clog2(FLUSH_LEN) + 1;
    localparam int FILL_W    = $clog2(WINDOW_LEN) + 1;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
    localparam logic [FLUSH_W-1:0] ZERO_WRITES = FLUSH_W'(WINDOW_LEN);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WINDOW_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_FILL  = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic        [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic        [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic        [DEC_WIDTH-1:0]  dec_cnt_q, dec_cnt_d;
    logic        [DEC_WIDTH-1:0]  dec_len_q, dec_len_d;
    logic                         ma_rst_q, ma_rst_d;
    logic signed [DATA_WIDTH-1:0] ma_din_q, ma_din_d;
    logic                         ma_din_valid_q, ma_din_valid_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                         dout_valid_q, dout_valid_d;
    logic                         filled_q, filled_d;
    logic                         pass_through;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            flush_cnt_q    <= '0;
            fill_cnt_q     <= '0;
            dec_cnt_q      <= '0;
            dec_len_q      <= DEC_WIDTH'(1);
            ma_rst_q       <= 1'b1;
            ma_din_q       <= '0;
            ma_din_valid_q <= 1'b0;
            dout_q         <= '0;
            dout_valid_q   <= 1'b0;
            filled_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            fill_cnt_q     <= fill_cnt_d;
            dec_cnt_q      <= dec_cnt_d;
            dec_len_q      <= dec_len_d;
            ma_rst_q       <= ma_rst_d;
            ma_din_q       <= ma_din_d;
            ma_din_valid_q <= ma_din_valid_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            filled_q       <= filled_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        fill_cnt_d     = fill_cnt_q;
        dec_cnt_d      = dec_cnt_q;
        dec_len_d      = dec_len_q;
        ma_din_d       = '0;
        ma_din_valid_d = 1'b0;
        dout_d         = dout_q;
        dout_valid_d   = 1'b0;
        pass_through   = 1'b0;

        if (!bus.enable) begin
            state_d = S_IDLE;
        end else if (bus.sync_in) begin
            // Any strobe (re)starts a full flush and re-latches the decimation length.
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
            fill_cnt_d  = '0;
            dec_cnt_d   = '0;
            dec_len_d   = (bus.dec_len == '0) ? DEC_WIDTH'(1) : bus.dec_len;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = S_FILL;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                    end
                end
                S_FILL: begin
                    if (bus.ma_dout_valid) begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                        if (fill_cnt_q == FILL_LAST) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.ma_dout_valid) begin
                        if (dec_cnt_q == dec_len_q - DEC_WIDTH'(1)) begin
                            dout_d       = bus.ma_dout;
                            dout_valid_d = 1'b1;
                            dec_cnt_d    = '0;
                        end else begin
                            dec_cnt_d = dec_cnt_q + DEC_WIDTH'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        pass_through = (state_q == S_FILL || state_q == S_RUN) &&
                       (state_d == S_FILL || state_d == S_RUN);
        if (state_d == S_FLUSH && flush_cnt_d < ZERO_WRITES) begin
            ma_din_valid_d = 1'b1;
        end else if (pass_through) begin
            ma_din_d       = bus.din;
            ma_din_valid_d = bus.din_valid;
        end
    end

    assign ma_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    assign filled_d = (state_d == S_RUN);

    assign bus.ma_rst       = ma_rst_q;
    assign bus.ma_din       = ma_din_q;
    assign bus.ma_din_valid = ma_din_valid_q;
    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.state        = state_q;
    assign bus.filled       = filled_q;
endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Directed bench for moving_avg_ctrl with a behavioural moving-average
// datapath (delay line + comb + integrator) closing the loop.
module tb_moving_avg_ctrl;
  localparam int WIN   = 16;
  localparam int DW    = 32;
  localparam int DECW  = 16;
  localparam int PLAT  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  moving_avg_ctrl_if #(.DATA_WIDTH(DW), .DEC_WIDTH(DECW)) bus ();

  moving_avg_ctrl #(
    .WINDOW_LEN(WIN), .DATA_WIDTH(DW), .DEC_WIDTH(DECW), .PIPE_LAT(PLAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural datapath, one cycle of latency; integrator held at zero
  // while ma_rst is high but the delay line is still written.
  int dl [WIN];
  int ptr;
  int acc;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) dl[i] <= 0;
      ptr               <= 0;
      acc               <= 0;
      bus.ma_dout       <= '0;
      bus.ma_dout_valid <= 1'b0;
    end else begin
      bus.ma_dout_valid <= 1'b0;
      if (bus.ma_rst) acc <= 0;
      if (bus.ma_din_valid) begin
        dl[ptr] <= int'(bus.ma_din);
        ptr     <= (ptr + 1) % WIN;
        if (!bus.ma_rst) begin
          acc               <= acc + int'(bus.ma_din) - dl[ptr];
          bus.ma_dout       <= (acc + int'(bus.ma_din) - dl[ptr]) >>> $clog2(WIN);
          bus.ma_dout_valid <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n_wr, n_zero, n_rst, n_fl, n_mdv, n_dv, first_wr, last_wr;
    bit got;

    rst = 1'b1;
    bus.enable    = 1'b1;
    bus.sync_in   = 1'b1;
    bus.dec_len   = 16'd4;
    bus.din       = '0;
    bus.din_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", bus.state, 2'd0);
      chk("rst_ma_rst", bus.ma_rst, 1'b1);
      chk("rst_dout_valid", bus.dout_valid, 1'b0);
      chk("rst_ma_din_valid", bus.ma_din_valid, 1'b0);
    end
    chk("rst_filled", bus.filled, 1'b0);
    chk("rst_dout", bus.dout, 32'sd0);

    rst = 1'b0;
    bus.sync_in = 1'b0;
    bus.enable  = 1'b0;
    tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    chk("sync_while_disabled_state", bus.state, 2'd0);

    // First flush; din_valid held high to show it is ignored.
    bus.enable    = 1'b1;
    bus.sync_in   = 1'b1;
    bus.din       = 32'sd1000;
    bus.din_valid = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    chk("flush_entry_state", bus.state, 2'd1);
    n_wr = 0; n_zero = 0; n_rst = 0; first_wr = -1; last_wr = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      if (bus.ma_din_valid) begin
        n_wr++;
        if (first_wr < 0) first_wr = i;
        last_wr = i;
        if (bus.ma_din === 32'sd0) n_zero++;
      end
      if (bus.ma_rst) n_rst++;
    end
    chk("flush_write_count", n_wr, 16);
    chk("flush_zero_writes", n_zero, 16);
    chk("flush_first_write", first_wr, 1);
    chk("flush_last_write", last_wr, 16);
    chk("flush_ma_rst_cycles", n_rst, 20);
    tick();
    chk("fill_entry_state", bus.state, 2'd2);
    chk("fill_entry_ma_rst", bus.ma_rst, 1'b0);
    chk("fill_entry_ma_din_valid", bus.ma_din_valid, 1'b0);

    // Fill: first WIN averages must be hidden.
    n_mdv = 0; n_dv = 0;
    for (int i = 0; i < 60 && n_mdv < 16; i++) begin
      tick();
      if (bus.dout_valid) n_dv++;
      if (bus.ma_dout_valid) n_mdv++;
    end
    chk("fill_outputs_seen", n_mdv, 16);
    chk("fill_dout_valid_count", n_dv, 0);
    chk("fill_state_at_16th", bus.state, 2'd2);
    tick();
    chk("run_filled", bus.filled, 1'b1);
    chk("run_state", bus.state, 2'd3);
    chk("run_entry_dout_valid", bus.dout_valid, 1'b0);

    // Decimate by 4; dec_len=0 written now must not take effect yet.
    bus.dec_len = 16'd0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("dec4_valid", bus.dout_valid, 1'((k % 4) == 0));
      if ((k % 4) == 0) chk("dec4_dout", bus.dout, 32'sd1000);
    end

    // Restart where dec_cnt has reached 2.
    tick();
    tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    chk("restart_state", bus.state, 2'd1);
    chk("restart_dout_valid", bus.dout_valid, 1'b0);
    chk("restart_dout_hold", bus.dout, 32'sd1000);
    for (int i = 0; i < 4; i++) tick();
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    n_fl = 0; n_zero = 0; n_dv = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      if (bus.state === 2'd1) n_fl++;
      if (bus.ma_din_valid && bus.ma_din === 32'sd0) n_zero++;
      if (bus.dout_valid) n_dv++;
    end
    chk("reflush_cycles", n_fl, 20);
    chk("reflush_zero_writes", n_zero, 16);
    chk("reflush_dout_valid", n_dv, 0);
    chk("reflush_dout_hold", bus.dout, 32'sd1000);
    tick();
    chk("reflush_fill_state", bus.state, 2'd2);

    // dec_len 0 latched as 1: first strobe after 16 fills + 1.
    n_mdv = 0; got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (bus.dout_valid) got = 1'b1;
      else if (bus.ma_dout_valid) n_mdv++;
    end
    chk("dec1_strobe_seen", got, 1'b1);
    chk("dec1_outputs_before", n_mdv, 17);
    chk("dec1_first_dout", bus.dout, 32'sd1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dec1_every_output", bus.dout_valid, 1'b1);
    end

    // Enable drop on a decimation-hit cycle in RUN.
    bus.enable = 1'b0;
    tick();
    chk("drop_run_state", bus.state, 2'd0);
    chk("drop_run_ma_rst", bus.ma_rst, 1'b1);
    chk("drop_run_dout_valid", bus.dout_valid, 1'b0);
    chk("drop_run_filled", bus.filled, 1'b0);
    chk("drop_run_ma_din_valid", bus.ma_din_valid, 1'b0);
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reenable_stays_idle", bus.state, 2'd0);
    end

    // Enable drop during FILL.
    bus.sync_in = 1'b1;
    tick();
    bus.sync_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("fill2_state", bus.state, 2'd2);
    for (int i = 0; i < 5; i++) tick();
    bus.enable = 1'b0;
    tick();
    chk("drop_fill_state", bus.state, 2'd0);
    chk("drop_fill_ma_rst", bus.ma_rst, 1'b1);
    chk("drop_fill_ma_din_valid", bus.ma_din_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
